// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter (arb_rr, arb_pri).
package arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int unsigned ARB_PTR_W(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/arb_pri.sv
// Rotated-priority find-first-set: one-hot winner of req, scanning from ptr upward mod N.
module arb_pri
    import arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = ARB_PTR_W(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic          any
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    // ptr + i < 2N always fits in PW+1 bits, so one conditional subtract gives mod N
    always_comb begin
        win   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/arb_rr.sv
// Registered round-robin arbiter with back-pressure hold.
// Optional multi-beat lock via `ARB_RR_LOCK_EN (adds the lock_i port).
module arb_rr
    import arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
`ifdef ARB_RR_LOCK_EN
    input  logic [N-1:0] lock_i,
`endif
    input  logic         rdy_i,
    output logic         vld_o,
    output logic [N-1:0] gnt_o,
    output logic [N-1:0] ack_o
);

    localparam int unsigned PW = ARB_PTR_W(N);

    arb_state_t    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] cur_idx;
    logic [PW-1:0] ptr_adv;
    logic [PW-1:0] pri_ptr;
    logic [N-1:0]  win;
    logic          any;
    logic          accept;
    logic          hold;

    always_comb begin
        cur_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_q[i]) begin
                cur_idx = PW'(i);
            end
        end
    end

    // Explicit wrap: N need not be a power of two
    assign ptr_adv = (cur_idx == PW'(N-1)) ? '0 : cur_idx + PW'(1);

    // On an accept the next winner is searched from the advanced pointer
    assign pri_ptr = (state_q == GRANT) ? ptr_adv : ptr_q;
    assign accept  = (state_q == GRANT) && rdy_i;

`ifdef ARB_RR_LOCK_EN
    assign hold = accept && |(gnt_q & lock_i & req_i);
`else
    assign hold = 1'b0;
`endif

    arb_pri #(
        .N  (N),
        .PW (PW)
    ) u_pri (
        .req (req_i),
        .ptr (pri_ptr),
        .win (win),
        .any (any)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = GRANT;
                    gnt_d   = win;
                end
            end
            GRANT: begin
                if (accept && !hold) begin
                    ptr_d = ptr_adv;
                    if (any) begin
                        gnt_d = win;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign vld_o = (state_q == GRANT);
    assign gnt_o = gnt_q;
    assign ack_o = gnt_q & {N{rdy_i}};

`ifndef SYNTHESIS
    // A granted requester must keep requesting until it has been acknowledged
    a_req_held: assert property (@(posedge clk) disable iff (rst)
        ((state_q == GRANT) && !rdy_i) |-> |(gnt_q & req_i));
    a_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(gnt_q) && (vld_o == |gnt_q));
`endif

endmodule

// File: doc/arb_rr.md
# arb_rr

Registered round-robin arbiter that turns N request lines into a one-hot grant vector for the downstream AND-OR `mux` select (`sel_i`) and its consumer. It holds the grant stable under back-pressure and rotates priority only on an accepted transfer. This gives single-cycle back-to-back throughput with fairness across requesters.

## Interface

- `N`, default 4: number of requesters; legal range N >= 2.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req_i`  in  N: request per requester.
  - Requester j holds `req_i[j]` until it sees `ack_o[j]`.
- `lock_i`  in  N: per-requester lock for multi-beat transfers.
  - Present only with `ARB_RR_LOCK_EN`.
- `rdy_i`  in  1: downstream ready.
- `vld_o`  out  1: a grant is valid.
- `gnt_o`  out  N: one-hot grant; drives `mux.sel_i` directly.
- `ack_o`  out  N: per-requester accept, `gnt_o & {N{rdy_i}}`.

## Operation

State machine, two states:
- IDLE: `vld_o`=0, `gnt_o`=0.
- GRANT: `vld_o`=1, `gnt_o` is one-hot.

Transitions:
- IDLE -> GRANT when |`req_i`.
- GRANT stays in GRANT while `rdy_i`=0. `gnt_o` is frozen and request changes are ignored.
- GRANT with `rdy_i`=1: transfer accepted.
  - Next state is GRANT if any arbitration candidate exists, else IDLE.

Priority pointer:
- `ptr` is a $clog2(N)-bit index; it names the highest-priority requester.
- Arbitration picks the first set bit of `req_i`, scanning `ptr`, `ptr`+1, ..., wrapping mod N.
- On accept of requester k, `ptr` becomes (k+1) mod N. The N-1 -> 0 wrap is explicit, because N need not be a power of two.
- On the accept cycle, the candidate set excludes nothing: requester k may win again only if no other requester is set.

Rules and boundary behaviour:
- `gnt_o` is always one-hot or zero; `vld_o` == |`gnt_o`.
- No request: stay/return to IDLE; `ptr` unchanged.
- A requester dropping `req_i` while granted is a protocol violation. The grant is held regardless; simulation-only assertion.
- Reset mid-operation: the next cycle has `vld_o`=0, `gnt_o`=0, `ptr`=0. Any in-flight grant is discarded.

Reset values:
- `vld_o`=0, `gnt_o`=0, `ack_o`=0, `ptr`=0, state IDLE.

## Timing

- Request-to-grant latency: `req_i` sampled at cycle t gives `gnt_o`/`vld_o` at t+1 (from IDLE).
- Back-to-back: an accept at cycle t with other requests pending gives the new grant at t+1. There are no bubbles, so throughput is one transfer per cycle.
- `gnt_o` and `vld_o` are flop outputs; no combinational path from `req_i` to them.
- `ack_o` is combinational from `rdy_i`. It is valid the same cycle as the accept.

## Configuration

- `ARB_RR_LOCK_EN` defined: `lock_i` port exists.
  - Accept by k with `lock_i[k]`=1: the next grant is forced to k, provided `req_i[k]`=1, and `ptr` is not advanced.
  - Accept with `lock_i[k]`=0 releases the lock and advances `ptr` normally.
  - While locked, all other requesters are starved.
- `ARB_RR_LOCK_EN` undefined: no `lock_i` port; pure round-robin as above.

## Structure

- Shared package `arb_pkg`:
  - state enum `arb_state_t` {IDLE, GRANT}.
  - localparam helper `ARB_PTR_W(N)` = $clog2(N).
- Sub-module `arb_pri`: combinational rotated priority find-first-set.
  - Inputs: `req`, `ptr`. Outputs: one-hot `win`, `any`.
  - `arb_rr` instantiates it once and registers `win` into `gnt_o`.

## Test plan

N=4 throughout.

1. Reset: hold `rst`=1 for 2 cycles with `req_i`=1111 -> `vld_o`=0, `gnt_o`=0000; the first grant after release is 0001.
2. Full load: `req_i`=1111, `rdy_i`=1 continuously -> `gnt_o` = 0001, 0010, 0100, 1000, 0001 on consecutive cycles, no bubbles.
3. Back-pressure: `req_i`=1010, `rdy_i`=0 for 5 cycles -> `gnt_o`=0010 stable, `ack_o`=0000. Raise `rdy_i` -> `ack_o`=0010, then `gnt_o`=1000 next cycle.
4. Wrap-around: accept requester 2 (`ptr`=3), then `req_i`=0011 -> `gnt_o`=0001 and `ptr` becomes 1 after accept.
5. Lock (`ARB_RR_LOCK_EN`): `req_i`=1111, `lock_i[1]`=1 for 3 beats then 0 -> `gnt_o` = 0010 for 4 beats, then 0100.
6. Reset mid-operation: assert `rst` while `gnt_o`=0100 and `rdy_i`=0 -> next cycle `vld_o`=0, `gnt_o`=0000. After release with `req_i`=1111, the grant is 0001.
